bpred_resolver: RTL and testbench
=================================

Name: bpred_resolver

Overview:
- Pipeline-side companion to the 1-bit branch predictor table.
- Issues prediction requests for fetched branches and captures each returned prediction with its PC in an in-order history FIFO.
- When the execute stage resolves a branch, pops the oldest entry, drives the predictor's result/update port, and flags mispredictions.
- Sits between fetch/execute control and the predictor instance.

Parameters:
PC_WIDTH, 32, PC width
LOG2FIFODEPTH, 2, log2 of outstanding-branch capacity
FIFO_DEPTH, 4, outstanding-branch capacity (2**LOG2FIFODEPTH)
CNTWIDTH, 16, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
br_fetch  input  1  fetch has a branch this cycle
br_fetch_pc  input  PC_WIDTH  PC of fetched branch
fetch_stall  output  1  history full; fetch must not assert br_fetch
predict  output  1  to predictor: predict next cycle
pc_predict  output  PC_WIDTH  to predictor: PC to predict
prediction  input  1  from predictor: valid cycle after predict
pred_valid  output  1  to fetch: prediction available this cycle
pred_taken  output  1  to fetch: predicted direction
br_resolve  input  1  execute resolved oldest outstanding branch
br_taken  input  1  actual direction
flush  input  1  squash all outstanding branches
result_rdy  output  1  to predictor: update strobe
result  output  1  to predictor: actual direction
pc_result  output  PC_WIDTH  to predictor: PC being updated
mispredict  output  1  one-cycle pulse, prediction was wrong
err_underflow  output  1  sticky: resolve with nothing outstanding
resolved_cnt  output  CNTWIDTH  resolved branches, saturating
mispred_cnt  output  CNTWIDTH  mispredicted branches, saturating

Behaviour:
- Reset (synchronous, active-high): FIFO empty; s1_valid=0; all outputs 0, including counters and err_underflow. Reset overrides every other input in the same cycle.
- Request stage (combinational):
  - predict = br_fetch & ~fetch_stall & ~flush.
  - pc_predict = br_fetch_pc.
- Capture stage:
  - Registers s1_valid and s1_pc on the cycle predict=1.
  - In the following cycle: pred_valid = s1_valid, pred_taken = prediction & s1_valid.
  - At the end of that cycle, {s1_pc, prediction} is pushed into the FIFO.
  - Latency: br_fetch at cycle N gives pred_valid at N+1; the entry is visible at the FIFO head no earlier than N+2.
- Occupancy:
  - Occupancy = FIFO count + s1_valid.
  - fetch_stall = (occupancy >= FIFO_DEPTH), combinational.
  - A br_fetch while fetch_stall=1 is dropped: no predict, no state change.
- Resolve:
  - br_resolve=1 with FIFO count>0 pops the head.
  - Registered outputs at the next cycle, held for exactly one cycle:
    - result_rdy=1
    - result=br_taken
    - pc_result=head PC
    - mispredict=(br_taken != head prediction)
  - resolved_cnt increments; mispred_cnt increments on mispredict. Both saturate at all-ones.
- Underflow: br_resolve with FIFO count=0 (even if s1_valid=1) is ignored. err_underflow sets and stays set until reset; no result_rdy; counters unchanged.
- Simultaneous push and pop in one cycle: both occur, count unchanged. The popped entry is the old head, never the entry being pushed.
- Pointers: read/write pointers wrap modulo FIFO_DEPTH. Count is LOG2FIFODEPTH+1 bits wide.
- Flush:
  - Clears the FIFO count and pointers, and clears s1_valid.
  - A pending s1 capture is discarded (pred_valid still shows it this cycle; no push).
  - A br_resolve in the same cycle is processed first: head popped, result/mispredict issued next cycle.
  - br_fetch in the flush cycle is ignored.
- Reset mid-operation: outstanding entries are lost. No result_rdy is generated for them.
- result_rdy, result, pc_result and mispredict are 0 (pc_result holds its last value) when not strobing.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, fetch_stall=0, predict=0.
- br_fetch pc=0x100 at cycle 1, prediction=1 at cycle 2, br_resolve br_taken=0 at cycle 4 -> predict=1/pc_predict=0x100 at cycle 1; pred_valid=1/pred_taken=1 at cycle 2; result_rdy=1, result=0, pc_result=0x100, mispredict=1 at cycle 5; resolved_cnt=1, mispred_cnt=1.
- Back-to-back fetches 0x200,0x204,0x208,0x20C with no resolves -> fetch_stall=1 once occupancy reaches 4; fifth br_fetch gives predict=0. Resolve four times -> pc_result sequence 0x200,0x204,0x208,0x20C in order; stall deasserts after the first pop.
- Steady state with one fetch and one resolve every cycle for 20 cycles, pointers wrapping -> count stays constant, PCs returned in order, no err_underflow.
- Two entries outstanding plus s1 pending, flush with br_resolve br_taken=1 in the same cycle -> one result_rdy for the oldest PC; FIFO empty after; a resolve two cycles later sets err_underflow=1 and gives no result_rdy.
- Force 2**CNTWIDTH resolves with CNTWIDTH=4, all mispredicted -> resolved_cnt and mispred_cnt stop at 15.

Source files
------------

// File: rtl/bpred_resolver_if.sv
// Signal bundle between bpred_resolver and its fetch, execute and predictor neighbours.
// The slave modport is the resolver's view; the master modport is the surrounding pipeline's view.
interface bpred_resolver_if #(
   parameter int PC_WIDTH = 32,
   parameter int CNTWIDTH = 16
);
   logic                br_fetch;
   logic [PC_WIDTH-1:0] br_fetch_pc;
   logic                fetch_stall;
   logic                predict;
   logic [PC_WIDTH-1:0] pc_predict;
   logic                prediction;
   logic                pred_valid;
   logic                pred_taken;
   logic                br_resolve;
   logic                br_taken;
   logic                flush;
   logic                result_rdy;
   logic                result;
   logic [PC_WIDTH-1:0] pc_result;
   logic                mispredict;
   logic                err_underflow;
   logic [CNTWIDTH-1:0] resolved_cnt;
   logic [CNTWIDTH-1:0] mispred_cnt;

   modport slave (
      input  br_fetch, br_fetch_pc, prediction, br_resolve, br_taken, flush,
      output fetch_stall, predict, pc_predict, pred_valid, pred_taken,
             result_rdy, result, pc_result, mispredict, err_underflow,
             resolved_cnt, mispred_cnt
   );

   modport master (
      output br_fetch, br_fetch_pc, prediction, br_resolve, br_taken, flush,
      input  fetch_stall, predict, pc_predict, pred_valid, pred_taken,
             result_rdy, result, pc_result, mispredict, err_underflow,
             resolved_cnt, mispred_cnt
   );
endinterface

// File: rtl/bpred_resolver.sv
// Issues branch predictions, keeps {PC, prediction} of in-flight branches in an in-order FIFO,
// and on resolution drives the predictor update port and flags mispredictions.
module bpred_resolver #(
   parameter int PC_WIDTH      = 32,
   parameter int LOG2FIFODEPTH = 2,
   parameter int FIFO_DEPTH    = 2**LOG2FIFODEPTH,
   parameter int CNTWIDTH      = 16
) (
   input  logic            clk,
   input  logic            reset,
   bpred_resolver_if.slave bus
);
   logic                     s1_valid_q;
   logic [PC_WIDTH-1:0]      s1_pc_q;
   logic [PC_WIDTH-1:0]      fifo_pc_q   [FIFO_DEPTH];
   logic                     fifo_pred_q [FIFO_DEPTH];
   logic [LOG2FIFODEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG2FIFODEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2FIFODEPTH:0]   count_q, count_d;
   logic [LOG2FIFODEPTH+1:0] occupancy;
   logic                     fetch_stall, predict, push, pop, fifo_empty;
   logic                     head_pred;
   logic [PC_WIDTH-1:0]      head_pc;
   logic                     result_rdy_q, result_q, mispredict_q, err_underflow_q;
   logic [PC_WIDTH-1:0]      pc_result_q;
   logic [CNTWIDTH-1:0]      resolved_cnt_q, mispred_cnt_q;

   assign fifo_empty  = (count_q == '0);
   // The capture register counts toward capacity so a push can never find the FIFO full.
   assign occupancy   = {1'b0, count_q} + (LOG2FIFODEPTH+2)'(s1_valid_q);
   assign fetch_stall = (occupancy >= (LOG2FIFODEPTH+2)'(FIFO_DEPTH));
   assign predict     = bus.br_fetch & ~fetch_stall & ~bus.flush;
   assign push        = s1_valid_q & ~bus.flush;
   assign pop         = bus.br_resolve & ~fifo_empty;
   assign head_pc     = fifo_pc_q[rd_ptr_q];
   assign head_pred   = fifo_pred_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + (LOG2FIFODEPTH)'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + (LOG2FIFODEPTH)'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (LOG2FIFODEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG2FIFODEPTH+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]   <= s1_pc_q;
         fifo_pred_q[wr_ptr_q] <= bus.prediction;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q      <= 1'b0;
         s1_pc_q         <= '0;
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         result_rdy_q    <= 1'b0;
         result_q        <= 1'b0;
         mispredict_q    <= 1'b0;
         pc_result_q     <= '0;
         err_underflow_q <= 1'b0;
         resolved_cnt_q  <= '0;
         mispred_cnt_q   <= '0;
      end else begin
         s1_valid_q <= predict;
         if (predict) s1_pc_q <= bus.br_fetch_pc;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         result_rdy_q <= pop;
         result_q     <= pop & bus.br_taken;
         mispredict_q <= pop & (bus.br_taken != head_pred);
         if (pop) begin
            pc_result_q <= head_pc;
            if (resolved_cnt_q != '1) resolved_cnt_q <= resolved_cnt_q + CNTWIDTH'(1);
            if ((bus.br_taken != head_pred) && (mispred_cnt_q != '1))
               mispred_cnt_q <= mispred_cnt_q + CNTWIDTH'(1);
         end
         if (bus.br_resolve && fifo_empty) err_underflow_q <= 1'b1;
      end
   end

   assign bus.fetch_stall   = fetch_stall;
   assign bus.predict       = predict;
   assign bus.pc_predict    = bus.br_fetch_pc;
   assign bus.pred_valid    = s1_valid_q;
   assign bus.pred_taken    = bus.prediction & s1_valid_q;
   assign bus.result_rdy    = result_rdy_q;
   assign bus.result        = result_q;
   assign bus.pc_result     = pc_result_q;
   assign bus.mispredict    = mispredict_q;
   assign bus.err_underflow = err_underflow_q;
   assign bus.resolved_cnt  = resolved_cnt_q;
   assign bus.mispred_cnt   = mispred_cnt_q;
endmodule

// File: tb/tb_bpred_resolver.sv
// Scoreboard bench for bpred_resolver: directed stimulus queues expected predictions/results,
// a negedge monitor pops and compares them; a second instance with 4-bit counters covers saturation.
module tb_bpred_resolver;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   typedef struct {
      logic [31:0] pc;
      logic        res;
      logic        mis;
   } res_t;

   res_t res_q[$];
   logic pred_q[$];

   bpred_resolver_if #(.PC_WIDTH(32), .CNTWIDTH(16)) bus ();
   bpred_resolver_if #(.PC_WIDTH(32), .CNTWIDTH(4))  bus2 ();

   bpred_resolver #(.PC_WIDTH(32), .LOG2FIFODEPTH(2), .FIFO_DEPTH(4), .CNTWIDTH(16)) u_dut (
      .clk(clk), .reset(rst), .bus(bus)
   );
   bpred_resolver #(.PC_WIDTH(32), .LOG2FIFODEPTH(2), .FIFO_DEPTH(4), .CNTWIDTH(4)) u_sat (
      .clk(clk), .reset(rst), .bus(bus2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic f, input logic [31:0] pc, input logic p,
                      input logic r, input logic t, input logic fl);
      bus.br_fetch    = f;
      bus.br_fetch_pc = pc;
      bus.prediction  = p;
      bus.br_resolve  = r;
      bus.br_taken    = t;
      bus.flush       = fl;
      #1;
   endtask

   task automatic drv2(input logic f, input logic [31:0] pc, input logic p,
                       input logic r, input logic t);
      bus2.br_fetch    = f;
      bus2.br_fetch_pc = pc;
      bus2.prediction  = p;
      bus2.br_resolve  = r;
      bus2.br_taken    = t;
      bus2.flush       = 1'b0;
      #1;
   endtask

   task automatic exp_res(input logic [31:0] pc, input logic res, input logic mis);
      res_t e;
      e.pc  = pc;
      e.res = res;
      e.mis = mis;
      res_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.result_rdy) begin
         if (res_q.size() == 0) begin
            chk("result_rdy_unexpected", {31'b0, bus.result_rdy}, 32'd0);
         end else begin
            res_t e;
            e = res_q.pop_front();
            chk("pc_result", bus.pc_result, e.pc);
            chk("result", {31'b0, bus.result}, {31'b0, e.res});
            chk("mispredict", {31'b0, bus.mispredict}, {31'b0, e.mis});
         end
      end else begin
         chk("idle_result_zero", {30'b0, bus.result, bus.mispredict}, 32'd0);
      end
      if (bus.pred_valid) begin
         if (pred_q.size() == 0) begin
            chk("pred_valid_unexpected", {31'b0, bus.pred_valid}, 32'd0);
         end else begin
            logic ep;
            ep = pred_q.pop_front();
            chk("pred_taken", {31'b0, bus.pred_taken}, {31'b0, ep});
         end
      end else begin
         chk("idle_pred_taken_zero", {31'b0, bus.pred_taken}, 32'd0);
      end
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      drv2(0, 0, 0, 0, 0);
      repeat (3) tick();
      rst = 1'b0;

      // Reset then idle
      repeat (5) tick();
      chk("rst_fetch_stall", {31'b0, bus.fetch_stall}, 32'd0);
      chk("rst_predict", {31'b0, bus.predict}, 32'd0);
      chk("rst_pred_valid", {31'b0, bus.pred_valid}, 32'd0);
      chk("rst_result_rdy", {31'b0, bus.result_rdy}, 32'd0);
      chk("rst_pc_result", bus.pc_result, 32'd0);
      chk("rst_err_underflow", {31'b0, bus.err_underflow}, 32'd0);
      chk("rst_resolved_cnt", {16'b0, bus.resolved_cnt}, 32'd0);
      chk("rst_mispred_cnt", {16'b0, bus.mispred_cnt}, 32'd0);

      // Single branch, predicted taken, actually not taken
      drv(1, 32'h100, 0, 0, 0, 0);
      chk("t2_predict", {31'b0, bus.predict}, 32'd1);
      chk("t2_pc_predict", bus.pc_predict, 32'h100);
      tick();
      drv(0, 0, 1, 0, 0, 0); pred_q.push_back(1'b1); tick();
      drv(0, 0, 0, 0, 0, 0); tick();
      drv(0, 0, 0, 1, 0, 0); exp_res(32'h100, 1'b0, 1'b1); tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("t2_resolved_cnt", {16'b0, bus.resolved_cnt}, 32'd1);
      chk("t2_mispred_cnt", {16'b0, bus.mispred_cnt}, 32'd1);
      tick();

      // Fill to capacity, fifth fetch dropped, then drain in order
      drv(1, 32'h200, 0, 0, 0, 0); tick();
      drv(1, 32'h204, 0, 0, 0, 0); pred_q.push_back(1'b0); tick();
      drv(1, 32'h208, 1, 0, 0, 0); pred_q.push_back(1'b1); tick();
      drv(1, 32'h20C, 0, 0, 0, 0); pred_q.push_back(1'b0);
      chk("t3_stall_occ3", {31'b0, bus.fetch_stall}, 32'd0);
      tick();
      drv(1, 32'h210, 1, 0, 0, 0); pred_q.push_back(1'b1);
      chk("t3_stall_occ4", {31'b0, bus.fetch_stall}, 32'd1);
      chk("t3_predict_dropped", {31'b0, bus.predict}, 32'd0);
      tick();
      drv(0, 0, 0, 1, 0, 0); exp_res(32'h200, 1'b0, 1'b0);
      chk("t3_stall_full", {31'b0, bus.fetch_stall}, 32'd1);
      tick();
      drv(0, 0, 0, 1, 0, 0); exp_res(32'h204, 1'b0, 1'b1);
      chk("t3_stall_after_pop", {31'b0, bus.fetch_stall}, 32'd0);
      tick();
      drv(0, 0, 0, 1, 1, 0); exp_res(32'h208, 1'b1, 1'b1); tick();
      drv(0, 0, 0, 1, 1, 0); exp_res(32'h20C, 1'b1, 1'b0); tick();
      drv(0, 0, 0, 0, 0, 0); tick();
      chk("t3_resolved_cnt", {16'b0, bus.resolved_cnt}, 32'd5);
      chk("t3_mispred_cnt", {16'b0, bus.mispred_cnt}, 32'd3);

      // Steady stream: entry k predicted k&1, actually taken when k%3==0
      for (int i = 0; i < 24; i++) begin
         logic        f, p, r, t;
         int          k;
         f = (i < 22);
         p = (i >= 1 && i <= 22) ? logic'((i - 1) & 1) : 1'b0;
         r = (i >= 2);
         k = i - 2;
         t = r && ((k % 3) == 0);
         if (i >= 1 && i <= 22) pred_q.push_back(p);
         if (r) exp_res(32'h300 + 32'(4 * k), t, t ^ logic'(k & 1));
         drv(f, 32'h300 + 32'(4 * i), p, r, t, 0);
         chk("t4_no_stall", {31'b0, bus.fetch_stall}, 32'd0);
         tick();
      end
      drv(0, 0, 0, 0, 0, 0); tick();
      chk("t4_resolved_cnt", {16'b0, bus.resolved_cnt}, 32'd27);
      chk("t4_mispred_cnt", {16'b0, bus.mispred_cnt}, 32'd14);
      chk("t4_no_underflow", {31'b0, bus.err_underflow}, 32'd0);

      // Flush with a same-cycle resolve; later resolve underflows
      drv(1, 32'h400, 0, 0, 0, 0); tick();
      drv(1, 32'h404, 0, 0, 0, 0); pred_q.push_back(1'b0); tick();
      drv(1, 32'h408, 1, 0, 0, 0); pred_q.push_back(1'b1); tick();
      drv(1, 32'h40C, 0, 1, 1, 1); pred_q.push_back(1'b0); exp_res(32'h400, 1'b1, 1'b1);
      chk("t5_predict_in_flush", {31'b0, bus.predict}, 32'd0);
      tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("t5_stall_after_flush", {31'b0, bus.fetch_stall}, 32'd0);
      tick();
      drv(0, 0, 0, 1, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("t5_err_underflow", {31'b0, bus.err_underflow}, 32'd1);
      tick(); tick();
      chk("t5_resolved_cnt", {16'b0, bus.resolved_cnt}, 32'd28);
      chk("t5_mispred_cnt", {16'b0, bus.mispred_cnt}, 32'd15);

      // Reset with branches outstanding
      drv(1, 32'h500, 0, 0, 0, 0); tick();
      drv(1, 32'h504, 1, 0, 0, 0); pred_q.push_back(1'b1); tick();
      drv(0, 0, 0, 0, 0, 0); pred_q.push_back(1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      chk("t6_err_cleared", {31'b0, bus.err_underflow}, 32'd0);
      chk("t6_resolved_cleared", {16'b0, bus.resolved_cnt}, 32'd0);
      chk("t6_mispred_cleared", {16'b0, bus.mispred_cnt}, 32'd0);
      tick();
      drv(0, 0, 0, 1, 1, 0); tick();
      drv(0, 0, 0, 0, 0, 0);
      chk("t6_fifo_emptied", {31'b0, bus.err_underflow}, 32'd1);
      tick(); tick();

      // Saturation on the 4-bit-counter instance: every branch mispredicted
      for (int i = 0; i < 20; i++) begin
         logic p, r;
         p = (i >= 1 && i <= 18);
         r = (i >= 2);
         drv2(i < 18, 32'h600 + 32'(4 * i), p, r, 1'b0);
         if (i == 16) begin
            chk("t7_resolved_14", {28'b0, bus2.resolved_cnt}, 32'd14);
            chk("t7_mispred_14", {28'b0, bus2.mispred_cnt}, 32'd14);
         end
         if (i == 17) chk("t7_resolved_15", {28'b0, bus2.resolved_cnt}, 32'd15);
         tick();
      end
      drv2(0, 0, 0, 0, 0); tick();
      chk("t7_resolved_sat", {28'b0, bus2.resolved_cnt}, 32'd15);
      chk("t7_mispred_sat", {28'b0, bus2.mispred_cnt}, 32'd15);
      chk("t7_no_underflow", {31'b0, bus2.err_underflow}, 32'd0);

      chk("res_queue_drained", res_q.size(), 32'd0);
      chk("pred_queue_drained", pred_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
